pipeline_mem_stage: RTL and testbench
=====================================

Name: pipeline_mem_stage

Overview:
- Parametrised next-generation memory/write stage of the CPU pipeline.
- Sits between the execute stage and writeback, and owns the flag register (N, Z, V, C) and delayed-branch condition evaluation.
- Stores go into a SB_DEPTH-entry posted store buffer that drains to a handshaked, multi-cycle RAM port; loads stall the pipe until they complete.

Parameters:
- DATA_W, 16, datapath width (result, store data, load data, delayed branch target).
- ADDR_W, 9, memory address width; mem_addr = result[ADDR_W-1:0].
- CTRL_W, 22, width of the control word passed through.
- SB_DEPTH, 4, store buffer entries (power of 2, >=2).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- control_in  in  CTRL_W  control word.
- result_in  in  DATA_W  ALU result / effective address.
- data_Rd_in  in  DATA_W  store data.
- is_load, is_store, flag_load  in  1 each  instruction class; flag_load updates flags.
- highbit_shifted_Rm_in, highbit_data_Rn_in, carry_in  in  1 each  operand sign bits / ALU carry.
- delayed_B_in  in  DATA_W  delayed branch target.
- delayed_cond_in  in  3  branch condition code.
- out_valid  out  1  instruction retired to writeback this cycle.
- result_out  out  DATA_W  registered result.
- load_data_out  out  DATA_W  load data (valid with out_valid on a load).
- control_out  out  CTRL_W  registered control word.
- N_out, Z_out, V_out, C_out  out  1 each  flag register outputs.
- delayed_B_out  out  DATA_W  registered branch target.
- do_delayed_B  out  1  take the delayed branch.
- mem_req, mem_we  out  1 each  RAM request / write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset (rst low, asynchronous):
  - all registers cleared; state IDLE; store buffer empty.
  - out_valid=0, mem_req=0, do_delayed_B=0, N/V/C=0, Z_out=1 (flag result register = 0).
- Acceptance:
  - in_ready = (state==IDLE) && !sb_full. sb_full is the registered count; there is no same-cycle pop credit.
  - Acceptance occurs when in_valid && in_ready.
- Non-memory ops and stores:
  - out_valid=1 the cycle after acceptance; result_out, control_out and delayed_B_out are registered at acceptance.
- Stores:
  - At acceptance, push {result[ADDR_W-1:0], data_Rd_in} into the store buffer.
- Store drain:
  - When the buffer is non-empty and the state is not LD_REQ/LD_WAIT, drive mem_req=1, mem_we=1 with the head entry.
  - On mem_gnt, pop the head entry.
  - Request signals stay stable until mem_gnt.
- Load state machine (IDLE → DRAIN_WAIT → LD_REQ → LD_WAIT → IDLE):
  - IDLE: an accepted load goes to DRAIN_WAIT.
  - DRAIN_WAIT: stay until the buffer is empty and no store request is pending, then go to LD_REQ.
  - LD_REQ: mem_req=1, mem_we=0, address held. On mem_gnt go to LD_WAIT.
  - LD_WAIT: on mem_rvalid, register mem_rdata into load_data_out and go to IDLE. out_valid=1 the following cycle.
  - Best-case load: accept at t, buffer empty, mem_req at t+1, gnt at t+1, rvalid at t+2, out_valid at t+3.
- Flags:
  - On acceptance with flag_load, capture {Rn high bit, Rm high bit, carry, result}.
  - N = result[DATA_W-1]; Z = (result==0); C = carry.
  - V=1 iff {Rn hi, Rm hi, res hi} is 011 or 100.
  - Flags hold otherwise.
- Delayed branch condition codes: NV=0, AL=1, EQ=2, NE=3, LT=4, LE=5, GT=6, GE=7.
  - The condition is registered at acceptance.
  - do_delayed_B is evaluated on the current flag register and gated by out_valid (0 when out_valid=0).
- Simultaneous events:
  - Push and pop in the same cycle leave the count unchanged.
  - Reset mid-load abandons the request and discards the buffer contents.
  - A mem_rvalid arriving outside LD_WAIT is ignored.

Decomposition:
- Package pipeline_mem_pkg:
  - cond-code localparams (NV..GE);
  - state enum {IDLE, DRAIN_WAIT, LD_REQ, LD_WAIT};
  - store buffer entry struct {addr, data}.
- Sub-module store_buffer:
  - parametrised FIFO (SB_DEPTH, entry width);
  - push/pop/full/empty/head outputs;
  - count register with wrap-around pointers.

Test Plan:
- Reset with rst=0 mid-operation → out_valid=0, mem_req=0, Z_out=1, in_ready=1 after release.
- ALU op result_in=0x8000, flag_load=1, cond=LT, Rn/Rm hi=0/1 → next cycle N=1, V=1, do_delayed_B=0 (N==V); same with cond=GE → do_delayed_B=1.
- Five back-to-back stores with mem_gnt=0, SB_DEPTH=4 → in_ready=0 after the 4th; raising mem_gnt drains entries in order (addr, data match), and in_ready returns once count<4.
- Store to 0x010 then load from 0x010 → load mem_req only after the store gnt; rvalid with 0xBEEF → load_data_out=0xBEEF and out_valid=1 the cycle after.
- Load with mem_gnt delayed 3 cycles → mem_req/mem_addr stable throughout, in_ready=0 until retire.
- cond=EQ on result 0 vs 1, and cond=NV/AL → do_delayed_B=1/0, 0/1; delayed_B_out equals the registered target.

Source files
------------

// File: rtl/pipeline_mem_stage_pkg.sv
// Shared types for the memory/write stage: condition codes, load FSM states,
// store buffer entry layout and the delayed-branch condition evaluator.
package pipeline_mem_pkg;

  localparam logic [2:0] CC_NV = 3'd0;
  localparam logic [2:0] CC_AL = 3'd1;
  localparam logic [2:0] CC_EQ = 3'd2;
  localparam logic [2:0] CC_NE = 3'd3;
  localparam logic [2:0] CC_LT = 3'd4;
  localparam logic [2:0] CC_LE = 3'd5;
  localparam logic [2:0] CC_GT = 3'd6;
  localparam logic [2:0] CC_GE = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN_WAIT,
    LD_REQ,
    LD_WAIT
  } state_e;

  localparam int SB_ADDR_W = 9;
  localparam int SB_DATA_W = 16;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  function automatic logic cond_eval(
    input logic [2:0] cc,
    input logic       n,
    input logic       z,
    input logic       v
  );
    logic t;
    t = 1'b0;
    case (cc)
      CC_NV: t = 1'b0;
      CC_AL: t = 1'b1;
      CC_EQ: t = z;
      CC_NE: t = !z;
      CC_LT: t = n ^ v;
      CC_LE: t = z | (n ^ v);
      CC_GT: t = !z & !(n ^ v);
      CC_GE: t = !(n ^ v);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pipeline_mem_stage_if.sv
// Handshaked RAM port between the memory stage (master) and the RAM (slave).
interface pipeline_mem_stage_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/pipeline_mem_stage_store_buffer.sv
// Posted store FIFO: power-of-two depth, wrap-around pointers, registered count.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int W     = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic         last
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wp_d  = wp_q + AW'(push);
    rp_d  = rp_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      if (push) mem_q[wp_q] <= din;
    end
  end

  assign head  = mem_q[rp_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign last  = (cnt_q == CW'(1));

endmodule

// File: rtl/pipeline_mem_stage.sv
// Memory/write stage: flag register, delayed-branch evaluation,
// posted store buffer and a blocking load state machine.
module pipeline_mem_stage
  import pipeline_mem_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 9,
  parameter int CTRL_W   = 22,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] data_Rd_in,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              flag_load,
  input  logic              highbit_shifted_Rm_in,
  input  logic              highbit_data_Rn_in,
  input  logic              carry_in,
  input  logic [DATA_W-1:0] delayed_B_in,
  input  logic [2:0]        delayed_cond_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] load_data_out,
  output logic [CTRL_W-1:0] control_out,
  output logic              N_out,
  output logic              Z_out,
  output logic              V_out,
  output logic              C_out,
  output logic [DATA_W-1:0] delayed_B_out,
  output logic              do_delayed_B,
  pipeline_mem_stage_if.master mem
);
  localparam int EW = ADDR_W + DATA_W;

  state_e state_q, state_d;

  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic [DATA_W-1:0] db_q, db_d;
  logic [DATA_W-1:0] fres_q, fres_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [2:0]        cond_q, cond_d;
  logic              ov_q, ov_d;
  logic              frn_q, frn_d;
  logic              frm_q, frm_d;
  logic              fc_q, fc_d;

  logic          sb_push, sb_pop;
  logic          sb_full, sb_empty, sb_last;
  logic [EW-1:0] sb_head;
  logic          acc, st_req, drained, rd_done;

  assign in_ready = (state_q == IDLE) && !sb_full;
  assign acc      = in_valid && in_ready;
  assign st_req   = !sb_empty && (state_q == IDLE || state_q == DRAIN_WAIT);
  assign sb_push  = acc && is_store && !is_load;
  assign sb_pop   = st_req && mem.mem_gnt;
  assign rd_done  = (state_q == LD_WAIT) && mem.mem_rvalid;
  // Buffer is empty at the next edge: nothing queued or the last entry leaves now.
  assign drained  = sb_empty || (sb_last && sb_pop);

  store_buffer #(
    .DEPTH (SB_DEPTH),
    .W     (EW)
  ) u_sb (
    .clk   (clk),
    .rst   (rst),
    .push  (sb_push),
    .pop   (sb_pop),
    .din   ({result_in[ADDR_W-1:0], data_Rd_in}),
    .head  (sb_head),
    .full  (sb_full),
    .empty (sb_empty),
    .last  (sb_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      result_q  <= '0;
      ld_data_q <= '0;
      db_q      <= '0;
      fres_q    <= '0;
      ctrl_q    <= '0;
      cond_q    <= '0;
      ov_q      <= 1'b0;
      frn_q     <= 1'b0;
      frm_q     <= 1'b0;
      fc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      ld_data_q <= ld_data_d;
      db_q      <= db_d;
      fres_q    <= fres_d;
      ctrl_q    <= ctrl_d;
      cond_q    <= cond_d;
      ov_q      <= ov_d;
      frn_q     <= frn_d;
      frm_q     <= frm_d;
      fc_q      <= fc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (acc && is_load) state_d = drained ? LD_REQ : DRAIN_WAIT;
      DRAIN_WAIT: if (drained) state_d = LD_REQ;
      LD_REQ:     if (mem.mem_gnt) state_d = LD_WAIT;
      LD_WAIT:    if (mem.mem_rvalid) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    result_d  = result_q;
    ctrl_d    = ctrl_q;
    db_d      = db_q;
    cond_d    = cond_q;
    fres_d    = fres_q;
    frn_d     = frn_q;
    frm_d     = frm_q;
    fc_d      = fc_q;
    ld_data_d = rd_done ? mem.mem_rdata : ld_data_q;
    ov_d      = (acc && !is_load) || rd_done;
    if (acc) begin
      result_d = result_in;
      ctrl_d   = control_in;
      db_d     = delayed_B_in;
      cond_d   = delayed_cond_in;
    end
    if (acc && flag_load) begin
      fres_d = result_in;
      frn_d  = highbit_data_Rn_in;
      frm_d  = highbit_shifted_Rm_in;
      fc_d   = carry_in;
    end
  end

  always_comb begin
    N_out = fres_q[DATA_W-1];
    Z_out = (fres_q == '0);
    C_out = fc_q;
    V_out = ({frn_q, frm_q, N_out} == 3'b011) ||
            ({frn_q, frm_q, N_out} == 3'b100);
    do_delayed_B  = ov_q && cond_eval(cond_q, N_out, Z_out, V_out);
    mem.mem_req   = st_req || (state_q == LD_REQ);
    mem.mem_we    = st_req;
    mem.mem_addr  = st_req ? sb_head[EW-1:DATA_W] : result_q[ADDR_W-1:0];
    mem.mem_wdata = st_req ? sb_head[DATA_W-1:0] : '0;
  end

  assign out_valid     = ov_q;
  assign result_out    = result_q;
  assign load_data_out = ld_data_q;
  assign control_out   = ctrl_q;
  assign delayed_B_out = db_q;

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Random plus directed bench for pipeline_mem_stage against an
// instruction-level model with architectural memory and a store queue.
module tb_pipeline_mem_stage;
  import pipeline_mem_pkg::*;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 9;
  localparam int CTRL_W   = 22;
  localparam int SB_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [CTRL_W-1:0] control_in;
  logic [DATA_W-1:0] result_in, data_Rd_in, delayed_B_in;
  logic              is_load, is_store, flag_load;
  logic              rm_hi, rn_hi, carry_in;
  logic [2:0]        delayed_cond_in;
  logic              out_valid;
  logic [DATA_W-1:0] result_out, load_data_out, delayed_B_out;
  logic [CTRL_W-1:0] control_out;
  logic              N_out, Z_out, V_out, C_out, do_delayed_B;

  pipeline_mem_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

  pipeline_mem_stage #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .SB_DEPTH(SB_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .control_in(control_in), .result_in(result_in), .data_Rd_in(data_Rd_in),
    .is_load(is_load), .is_store(is_store), .flag_load(flag_load),
    .highbit_shifted_Rm_in(rm_hi), .highbit_data_Rn_in(rn_hi),
    .carry_in(carry_in),
    .delayed_B_in(delayed_B_in), .delayed_cond_in(delayed_cond_in),
    .out_valid(out_valid), .result_out(result_out),
    .load_data_out(load_data_out), .control_out(control_out),
    .N_out(N_out), .Z_out(Z_out), .V_out(V_out), .C_out(C_out),
    .delayed_B_out(delayed_B_out), .do_delayed_B(do_delayed_B),
    .mem(mif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] res;
    logic [21:0] ctrl;
    logic [15:0] db;
    logic        is_ld;
    logic [15:0] ld_data;
    logic        n, z, v, c, dob;
    int          due;
  } exp_t;

  exp_t        expq[$];
  sb_entry_t   sbq[$];
  logic [15:0] arch[512];
  logic [15:0] ram[512];
  logic        mn, mz, mv, mc;
  logic        ld_pend, ld_granted;
  logic [8:0]  ld_addr;
  logic        prev_hold;
  logic [8:0]  p_addr;
  logic [15:0] p_wdata;
  logic        p_we;
  int          gnt_pct = 100;
  bit          spur_en = 0;

  function automatic logic take(input logic [2:0] cc, input logic n, z, v);
    case (cc)
      CC_AL:   return 1'b1;
      CC_EQ:   return z;
      CC_NE:   return !z;
      CC_LT:   return n != v;
      CC_LE:   return z || (n != v);
      CC_GT:   return !z && (n == v);
      CC_GE:   return n == v;
      default: return 1'b0;
    endcase
  endfunction

  // RAM slave: writes land on grant, reads return 0..3 cycles after grant.
  logic       rd_pend = 1'b0;
  logic [8:0] rd_addr;
  int         rd_cnt;
  always @(posedge clk) begin
    if (rst && mif.mem_req && mif.mem_gnt) begin
      if (mif.mem_we) ram[mif.mem_addr] = mif.mem_wdata;
      else begin
        rd_pend = 1'b1;
        rd_addr = mif.mem_addr;
        rd_cnt  = $urandom_range(0, 3);
      end
    end
    #2;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = 16'($urandom);
    if (!rst) begin
      rd_pend     = 1'b0;
      mif.mem_gnt = 1'b0;
    end else begin
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          mif.mem_rvalid = 1'b1;
          mif.mem_rdata  = ram[rd_addr];
          rd_pend        = 1'b0;
        end else rd_cnt--;
      end else if (spur_en && $urandom_range(0, 9) == 0) mif.mem_rvalid = 1'b1;
      mif.mem_gnt = mif.mem_req && ($urandom_range(1, 100) <= gnt_pct);
    end
  end

  // Compare process: retire checks, then apply events of the coming edge.
  always @(negedge clk) begin : cmp
    exp_t      e;
    sb_entry_t s;
    logic      rdy;
    cyc++;
    if (!rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_mem_req", mif.mem_req, 0);
      chk("rst_Z", Z_out, 1);
      chk("rst_NVC", {N_out, V_out, C_out}, 0);
      chk("rst_do_B", do_delayed_B, 0);
      expq.delete();
      sbq.delete();
      ld_pend = 0; ld_granted = 0; prev_hold = 0;
      mn = 0; mz = 1; mv = 0; mc = 0;
      for (int i = 0; i < 512; i++) arch[i] = ram[i];
    end else begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_retire: out_valid 1 required 0 (cycle %0d)", cyc);
        end else begin
          e = expq.pop_front();
          chk("retire_cycle", cyc, e.due);
          chk("result_out", result_out, e.res);
          chk("control_out", control_out, e.ctrl);
          chk("delayed_B_out", delayed_B_out, e.db);
          chk("flags_NZVC", {N_out, Z_out, V_out, C_out}, {e.n, e.z, e.v, e.c});
          chk("do_delayed_B", do_delayed_B, e.dob);
          if (e.is_ld) chk("load_data_out", load_data_out, e.ld_data);
        end
      end else begin
        chk("do_B_gated", do_delayed_B, 0);
        if (expq.size() > 0 && expq[0].due >= 0 && expq[0].due <= cyc) begin
          checks++; errors++;
          $display("FAIL missed_retire: out_valid 0 required 1 (cycle %0d)", cyc);
          void'(expq.pop_front());
        end
      end
      rdy = !ld_pend && (sbq.size() < SB_DEPTH);
      chk("in_ready", in_ready, rdy);
      chk("mem_req", mif.mem_req, (sbq.size() > 0) || (ld_pend && !ld_granted));
      if (mif.mem_req) chk("mem_we", mif.mem_we, sbq.size() > 0);
      if (prev_hold) begin
        chk("hold_req", mif.mem_req, 1);
        chk("hold_we", mif.mem_we, p_we);
        chk("hold_addr", mif.mem_addr, p_addr);
        chk("hold_wdata", mif.mem_wdata, p_wdata);
      end
      prev_hold = mif.mem_req && !mif.mem_gnt;
      p_we = mif.mem_we; p_addr = mif.mem_addr; p_wdata = mif.mem_wdata;

      if (mif.mem_rvalid && ld_granted && expq.size() > 0) begin
        expq[expq.size()-1].due = cyc + 1;
        ld_pend = 0; ld_granted = 0;
      end
      if (mif.mem_req && mif.mem_gnt) begin
        if (mif.mem_we) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_store: write to %0h with empty model queue", mif.mem_addr);
          end else begin
            s = sbq.pop_front();
            chk("store_addr", mif.mem_addr, s.addr);
            chk("store_data", mif.mem_wdata, s.data);
          end
        end else begin
          chk("load_addr", mif.mem_addr, ld_addr);
          ld_granted = 1;
        end
      end
      if (in_valid && rdy) begin
        if (flag_load) begin
          mn = result_in[15];
          mz = (result_in == 16'h0);
          mc = carry_in;
          mv = ({rn_hi, rm_hi, result_in[15]} == 3'b011) ||
               ({rn_hi, rm_hi, result_in[15]} == 3'b100);
        end
        e.res = result_in; e.ctrl = control_in; e.db = delayed_B_in;
        e.is_ld = is_load; e.ld_data = arch[result_in[8:0]];
        e.n = mn; e.z = mz; e.v = mv; e.c = mc;
        e.dob = take(delayed_cond_in, mn, mz, mv);
        e.due = is_load ? -1 : cyc + 1;
        expq.push_back(e);
        if (is_load) begin
          ld_pend = 1; ld_addr = result_in[8:0];
        end else if (is_store) begin
          sbq.push_back('{addr: result_in[8:0], data: data_Rd_in});
          arch[result_in[8:0]] = data_Rd_in;
        end
      end
    end
  end

  task automatic send(input logic ld, st, fl, input logic [15:0] res, dat, db,
                      input logic [2:0] cc, input logic rn, rm, c);
    bit ok = 0;
    in_valid = 1; is_load = ld; is_store = st; flag_load = fl;
    result_in = res; data_Rd_in = dat; delayed_B_in = db;
    delayed_cond_in = cc; rn_hi = rn; rm_hi = rm; carry_in = c;
    control_in = 22'($urandom);
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready 0 required 1 within 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 0; is_load = 0; is_store = 0; flag_load = 0;
  endtask

  task automatic wait_ov();
    bit seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL retire_timeout: out_valid 0 required 1 within 60 cycles");
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 0; in_valid = 0; is_load = 0; is_store = 0; flag_load = 0;
    result_in = 0; data_Rd_in = 0; delayed_B_in = 0; delayed_cond_in = 0;
    rn_hi = 0; rm_hi = 0; carry_in = 0; control_in = 0;
    mif.mem_gnt = 0; mif.mem_rvalid = 0; mif.mem_rdata = 0;
    for (int i = 0; i < 512; i++) begin
      ram[i] = 16'($urandom);
      arch[i] = ram[i];
    end
    repeat (3) @(posedge clk);
    #3 rst = 1;
    step();

    send(0, 0, 1, 16'h8000, 16'h0, 16'h0123, CC_LT, 0, 1, 0);
    @(negedge clk);
    chk("lt_out_valid", out_valid, 1);
    chk("lt_N", N_out, 1);
    chk("lt_V", V_out, 1);
    chk("lt_do_B", do_delayed_B, 0);
    step();
    send(0, 0, 1, 16'h8000, 16'h0, 16'h0123, CC_GE, 0, 1, 0);
    @(negedge clk);
    chk("ge_do_B", do_delayed_B, 1);
    step();

    send(0, 0, 1, 16'h0000, 16'h0, 16'h0ABC, CC_EQ, 0, 0, 1);
    @(negedge clk);
    chk("eq0_do_B", do_delayed_B, 1);
    chk("eq0_Z", Z_out, 1);
    chk("eq0_C", C_out, 1);
    chk("eq0_target", delayed_B_out, 16'h0ABC);
    step();
    send(0, 0, 1, 16'h0001, 16'h0, 16'h0ABD, CC_EQ, 0, 0, 0);
    @(negedge clk);
    chk("eq1_do_B", do_delayed_B, 0);
    step();
    send(0, 0, 0, 16'h0055, 16'h0, 16'h0666, CC_NV, 0, 0, 0);
    @(negedge clk);
    chk("nv_do_B", do_delayed_B, 0);
    step();
    send(0, 0, 0, 16'h0055, 16'h0, 16'h0777, CC_AL, 0, 0, 0);
    @(negedge clk);
    chk("al_do_B", do_delayed_B, 1);
    chk("al_target", delayed_B_out, 16'h0777);
    step();

    gnt_pct = 0;
    for (int i = 0; i < 4; i++)
      send(0, 1, 0, 16'(i + 1), 16'(16'hA000 + i), 16'h0, CC_NV, 0, 0, 0);
    repeat (2) begin
      @(negedge clk);
      chk("sb_full_in_ready", in_ready, 0);
    end
    step();
    gnt_pct = 100;
    @(negedge clk);
    chk("drain_head_addr", mif.mem_addr, 9'h001);
    chk("drain_head_data", mif.mem_wdata, 16'hA000);
    step();
    send(0, 1, 0, 16'h0005, 16'hA004, 16'h0, CC_NV, 0, 0, 0);
    repeat (10) step();

    gnt_pct = 0;
    send(0, 1, 0, 16'h0010, 16'hBEEF, 16'h0, CC_NV, 0, 0, 0);
    send(1, 0, 0, 16'h0010, 16'h0, 16'h0, CC_AL, 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("raw_store_first", mif.mem_we, 1);
      chk("raw_store_addr", mif.mem_addr, 9'h010);
    end
    step();
    gnt_pct = 100;
    wait_ov();
    chk("raw_load_data", load_data_out, 16'hBEEF);
    step();

    gnt_pct = 0;
    send(1, 0, 0, 16'h0055, 16'h0, 16'h0, CC_NE, 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ldw_req", mif.mem_req, 1);
      chk("ldw_we", mif.mem_we, 0);
      chk("ldw_addr", mif.mem_addr, 9'h055);
      chk("ldw_in_ready", in_ready, 0);
    end
    step();
    gnt_pct = 100;
    wait_ov();
    step();

    gnt_pct = 0;
    send(0, 1, 0, 16'h0020, 16'h1111, 16'h0, CC_NV, 0, 0, 0);
    send(1, 0, 0, 16'h0020, 16'h0, 16'h0, CC_NV, 0, 0, 0);
    @(posedge clk);
    #3 rst = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_mem_req", mif.mem_req, 0);
    chk("mid_rst_Z", Z_out, 1);
    @(posedge clk);
    #3 rst = 1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_mem_req", mif.mem_req, 0);
    step();
    gnt_pct = 100;

    spur_en = 1;
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [15:0] r;
      gnt_pct = $urandom_range(20, 100);
      repeat ($urandom_range(0, 2)) step();
      kind = $urandom_range(0, 99);
      r = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      if (kind < 40)
        send(0, 1, 1'($urandom), 16'($urandom_range(0, 15)), 16'($urandom),
             16'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      else if (kind < 65)
        send(1, 0, 1'($urandom), 16'($urandom_range(0, 15)), 16'($urandom),
             16'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      else
        send(0, 0, 1'($urandom), r, 16'($urandom),
             16'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    spur_en = 0;
    gnt_pct = 100;
    begin
      bit idle = 0;
      for (int k = 0; k < 200 && !idle; k++) begin
        @(negedge clk);
        if (expq.size() == 0 && sbq.size() == 0 && !ld_pend) idle = 1;
      end
      if (!idle) begin
        checks++; errors++;
        $display("FAIL final_drain: outstanding %0d retires %0d stores",
                 expq.size(), sbq.size());
      end
    end
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
